// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter
//   Drives the GRF write port (grf_we/grf_a3/grf_wd/grf_wpc) and is its only
//   source. W-stage writeback and MDU results are merged onto that port. A W
//   write always wins the port. MDU results are taken over a valid/ready
//   handshake and held in a small FIFO. They drain onto the port on cycles with
//   no effective W write. Decode is stalled while one of its source registers
//   is still waiting in the FIFO, and while the FIFO is full.
//
//   Ports
//     clk, reset                     clock (rising edge); asynchronous active-low reset
//     w_we, w_a3, w_wd, w_pc         W-stage write request (no backpressure)
//     md_valid, md_ready             MDU result handshake
//     md_a3, md_wd, md_pc            MDU result payload
//     q_a1, q_a2                     decode source registers
//     stall                          decode hold (combinational)
//     count                          FIFO occupancy, 0..DEPTH
//     grf_we, grf_a3, grf_wd, grf_wpc  registered GRF write port
module grf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_we,
    input  logic [AW-1:0]              w_a3,
    input  logic [DW-1:0]              w_wd,
    input  logic [DW-1:0]              w_pc,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [AW-1:0]              md_a3,
    input  logic [DW-1:0]              md_wd,
    input  logic [DW-1:0]              md_pc,
    input  logic [AW-1:0]              q_a1,
    input  logic [AW-1:0]              q_a2,
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       grf_we,
    output logic [AW-1:0]              grf_a3,
    output logic [DW-1:0]              grf_wd,
    output logic [DW-1:0]              grf_wpc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] fifo_a3 [DEPTH];
    logic [DW-1:0] fifo_wd [DEPTH];
    logic [DW-1:0] fifo_pc [DEPTH];
    logic [DEPTH-1:0] vld_p1;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic ew_p0;
    logic pop_p0;
    logic push_p0;
    logic full_p0;
    logic hit1_p0;
    logic hit2_p0;

    // ---- stage 0: decisions from the inputs and the current FIFO state ----
    // Writes to $0 are dropped. Dropping them keeps the port free for a drain.
    assign ew_p0    = w_we && (w_a3 != '0);
    assign full_p0  = (count == FULL_CNT);
    assign md_ready = (count < FULL_CNT);
    assign pop_p0   = !ew_p0 && (count != '0);
    // An MDU result for $0 completes its handshake and is not stored.
    assign push_p0  = md_valid && md_ready && (md_a3 != '0);

    // The head entry stays valid until the edge that pops it. A reader of
    // that register is stalled until then.
    always_comb begin
        hit1_p0 = 1'b0;
        hit2_p0 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_p1[i] && (q_a1 != '0) && (fifo_a3[i] == q_a1)) hit1_p0 = 1'b1;
            if (vld_p1[i] && (q_a2 != '0) && (fifo_a3[i] == q_a2)) hit2_p0 = 1'b1;
        end
    end

    assign stall = full_p0 || hit1_p0 || hit2_p0;

    // ---- stage 1: FIFO state and GRF write port registers ----
    // A full FIFO never accepts, so the push slot never coincides with the
    // slot being popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_p1 <= '0;
        end else begin
            if (push_p0) begin
                wr_ptr         <= wr_ptr + 1'b1;
                vld_p1[wr_ptr] <= 1'b1;
            end
            if (pop_p0) begin
                rd_ptr         <= rd_ptr + 1'b1;
                vld_p1[rd_ptr] <= 1'b0;
            end
            case ({push_p0, pop_p0})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) begin
            fifo_a3[wr_ptr] <= md_a3;
            fifo_wd[wr_ptr] <= md_wd;
            fifo_pc[wr_ptr] <= md_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grf_we  <= 1'b0;
            grf_a3  <= '0;
            grf_wd  <= '0;
            grf_wpc <= '0;
        end else if (ew_p0) begin
            grf_we  <= 1'b1;
            grf_a3  <= w_a3;
            grf_wd  <= w_wd;
            grf_wpc <= w_pc;
        end else if (pop_p0) begin
            grf_we  <= 1'b1;
            grf_a3  <= fifo_a3[rd_ptr];
            grf_wd  <= fifo_wd[rd_ptr];
            grf_wpc <= fifo_pc[rd_ptr];
        end else begin
            grf_we  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_grf_write_arbiter.sv
module tb_grf_write_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          w_we;
    logic [AW-1:0] w_a3;
    logic [DW-1:0] w_wd;
    logic [DW-1:0] w_pc;
    logic          md_valid;
    logic          md_ready;
    logic [AW-1:0] md_a3;
    logic [DW-1:0] md_wd;
    logic [DW-1:0] md_pc;
    logic [AW-1:0] q_a1;
    logic [AW-1:0] q_a2;
    logic          stall;
    logic [CW-1:0] count;
    logic          grf_we;
    logic [AW-1:0] grf_a3;
    logic [DW-1:0] grf_wd;
    logic [DW-1:0] grf_wpc;

    always #5 clk = ~clk;

    grf_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
        .md_valid(md_valid), .md_ready(md_ready),
        .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc),
        .q_a1(q_a1), .q_a2(q_a2), .stall(stall), .count(count),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_wpc(grf_wpc)
    );

    // Reference model: a queue of pending MDU results plus the expected GRF port.
    typedef struct {
        logic [AW-1:0] a3;
        logic [DW-1:0] wd;
        logic [DW-1:0] pc;
    } ent_t;

    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_pc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_pending(input logic [AW-1:0] x);
        if (x == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].a3 == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return (mq.size() == DEPTH) || m_pending(q_a1) || m_pending(q_a2);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
    endtask

    // Apply the rules for one rising edge to the model, using the sampled inputs.
    task automatic m_edge();
        bit accept;
        ent_t e;
        accept = md_valid && (mq.size() < DEPTH) && (md_a3 != 0);
        if (w_we && w_a3 != 0) begin
            m_we = 1'b1; m_a3 = w_a3; m_wd = w_wd; m_pc = w_pc;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_a3 = e.a3; m_wd = e.wd; m_pc = e.pc;
        end else begin
            m_we = 1'b0;
        end
        if (accept) begin
            e.a3 = md_a3; e.wd = md_wd; e.pc = md_pc;
            mq.push_back(e);
        end
    endtask

    task automatic chk_port(input string tag);
        chk({tag, ".grf_we"},  64'(grf_we),  64'(m_we));
        chk({tag, ".grf_a3"},  64'(grf_a3),  64'(m_a3));
        chk({tag, ".grf_wd"},  64'(grf_wd),  64'(m_wd));
        chk({tag, ".grf_wpc"}, 64'(grf_wpc), 64'(m_pc));
        chk({tag, ".count"},   64'(count),   64'(mq.size()));
    endtask

    // One clock cycle: starts 1 time unit after a rising edge.
    task automatic cyc(input string tag,
                       input logic we, input logic [AW-1:0] a3, input logic [DW-1:0] wd, input logic [DW-1:0] pc,
                       input logic mv, input logic [AW-1:0] ma3, input logic [DW-1:0] mwd, input logic [DW-1:0] mpc,
                       input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
        w_we = we; w_a3 = a3; w_wd = wd; w_pc = pc;
        md_valid = mv; md_a3 = ma3; md_wd = mwd; md_pc = mpc;
        q_a1 = qa1; q_a2 = qa2;
        #1;
        chk({tag, ".md_ready"}, 64'(md_ready), 64'(mq.size() < DEPTH));
        chk({tag, ".stall"},    64'(stall),    64'(m_stall()));
        @(posedge clk);
        m_edge();
        #1;
        chk_port(tag);
    endtask

    task automatic idle(input string tag, input logic [AW-1:0] qa1);
        cyc(tag, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, qa1, '0);
    endtask

    initial begin
        reset = 1'b0;
        w_we = 0; w_a3 = '0; w_wd = '0; w_pc = '0;
        md_valid = 0; md_a3 = '0; md_wd = '0; md_pc = '0;
        q_a1 = '0; q_a2 = '0;
        m_reset();
        #12;
        chk("rst.grf_we", 64'(grf_we), 64'd0);
        chk("rst.grf_a3", 64'(grf_a3), 64'd0);
        chk("rst.grf_wd", 64'(grf_wd), 64'd0);
        chk("rst.grf_wpc", 64'(grf_wpc), 64'd0);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.md_ready", 64'(md_ready), 64'd1);
        chk("rst.stall", 64'(stall), 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // W-only write, then an idle cycle.
        cyc("w_only", 1, 5'd5, 32'h1234, 32'h3000, 0, '0, '0, '0, '0, '0);
        chk("w_only.a3_const", 64'(grf_a3), 64'd5);
        chk("w_only.wd_const", 64'(grf_wd), 64'h1234);
        idle("w_only_idle", '0);
        chk("w_only_idle.we_const", 64'(grf_we), 64'd0);

        // $0 filtering on both sources.
        cyc("zero_w", 1, 5'd0, 32'hdead, 32'h10, 0, '0, '0, '0, '0, '0);
        cyc("zero_md", 0, '0, '0, '0, 1, 5'd0, 32'hbeef, 32'h20, '0, '0);
        chk("zero_md.count_const", 64'(count), 64'd0);

        // Collision: MDU $8 waits behind two W writes to $9.
        cyc("col0", 0, '0, '0, '0, 1, 5'd8, 32'h88, 32'h400, 5'd8, '0);
        cyc("col1", 1, 5'd9, 32'h91, 32'h404, 0, '0, '0, '0, 5'd8, '0);
        chk("col1.stall_const", 64'(stall), 64'd1);
        cyc("col2", 1, 5'd9, 32'h92, 32'h408, 0, '0, '0, '0, 5'd8, '0);
        idle("col3", 5'd8);
        chk("col3.a3_const", 64'(grf_a3), 64'd8);
        idle("col4", 5'd8);

        // Full FIFO and pointer wrap, three rounds.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++)
                cyc("fill", 1, 5'd1, 32'(k), 32'h500, 1, 5'(10 + k), 32'(100 * r + k), 32'(k), 5'd20, '0);
            cyc("full", 1, 5'd1, 32'h0, 32'h500, 1, 5'd30, 32'hf, 32'hf, 5'd2, '0);
            chk("full.md_ready_const", 64'(md_ready), 64'd0);
            for (int k = 0; k < DEPTH + 1; k++) idle("drain", 5'(10 + k));
        end

        // Simultaneous push and pop with two entries pending.
        cyc("sim0", 1, 5'd3, 32'h1, 32'h1, 1, 5'd4, 32'h41, 32'h41, '0, '0);
        cyc("sim1", 1, 5'd3, 32'h2, 32'h2, 1, 5'd6, 32'h61, 32'h61, '0, '0);
        cyc("sim2", 0, '0, '0, '0, 1, 5'd7, 32'h71, 32'h71, 5'd7, 5'd4);
        chk("sim2.count_const", 64'(count), 64'd2);
        for (int k = 0; k < 3; k++) idle("sim_drain", 5'd6);

        // Randomized traffic with phases of heavy and light W load.
        for (int n = 0; n < 3000; n++) begin
            int wp;
            wp = ((n / 50) % 2 == 0) ? 90 : 25;
            cyc("rand",
                $urandom_range(99) < wp, 5'($urandom_range(7)), $urandom, $urandom,
                $urandom_range(99) < 50, 5'($urandom_range(7)), $urandom, $urandom,
                5'($urandom_range(7)), 5'($urandom_range(7)));
        end

        // Asynchronous reset with entries pending and a write in flight.
        cyc("ar0", 1, 5'd1, 32'h1, 32'h1, 1, 5'd2, 32'h2, 32'h2, '0, '0);
        cyc("ar1", 1, 5'd1, 32'h1, 32'h1, 1, 5'd3, 32'h3, 32'h3, '0, '0);
        cyc("ar2", 1, 5'd1, 32'h1, 32'h1, 1, 5'd5, 32'h5, 32'h5, 5'd3, '0);
        w_we = 0; md_valid = 0; q_a1 = 5'd3;
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk("arst.grf_we", 64'(grf_we), 64'd0);
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.md_ready", 64'(md_ready), 64'd1);
        chk("arst.stall", 64'(stall), 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk_port("post_rst");
        for (int k = 0; k < 4; k++)
            cyc("post", 1, 5'(k + 1), 32'(k), 32'(k), 1, 5'(k + 4), 32'(k), 32'(k), 5'd4, '0);
        for (int k = 0; k < 6; k++) idle("post_drain", 5'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
